// File: rtl/gc_mem_ctrl.sv
// Byte-lane data memory with a valid/ready request port, a registered read response,
// out-of-range error reporting and a hardware clear sequencer (after reset and on request).
module gc_mem_ctrl #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr_req,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [LANES-1:0]     req_be,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [8*LANES-1:0]   req_wd,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [8*LANES-1:0]   rsp_rd,
   output logic                 rsp_err,
   output logic                 init_done
);

   localparam int LG    = (LANES > 1) ? $clog2(LANES) : 0;
   localparam int IDX_W = ADDR_W - LG;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W:0] DEPTH_X = (IDX_W+1)'(DEPTH);
   localparam logic [AW-1:0]  LAST    = AW'(DEPTH - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t               state_q, state_d;
   logic [AW-1:0]        cnt_q, cnt_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [8*LANES-1:0]   rsp_rd_q, rsp_rd_d;
   logic                 rsp_err_q, rsp_err_d;

   logic [IDX_W-1:0]     idx;
   logic [AW-1:0]        idx_m;
   logic                 in_range;
   logic                 accept;
   logic                 wr_acc;
   logic                 rd_acc;
   logic                 clr_we;
   logic [8*LANES-1:0]   rd_word;

   // Sub-word address bits carry no meaning: accesses are always whole-word aligned.
   assign idx      = req_addr[ADDR_W-1:LG];
   assign idx_m    = idx[AW-1:0];
   assign in_range = ({1'b0, idx} < DEPTH_X);

   if (LG > 0) begin : g_unused_lo
      logic unused_lo;
      assign unused_lo = ^req_addr[LG-1:0];
   end

   assign init_done = (state_q == RUN);
   assign req_ready = (state_q == RUN) && (!rsp_valid_q || rsp_ready);
   assign accept    = req_valid && req_ready;
   assign wr_acc    = accept && req_we && in_range;
   assign rd_acc    = accept && !req_we;
   assign clr_we    = (state_q == CLEAR);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [7:0] mem_q [DEPTH];

      always_ff @(posedge clk) begin
         if (clr_we) begin
            mem_q[cnt_q] <= '0;
         end else if (wr_acc && req_be[i]) begin
            mem_q[idx_m] <= req_wd[8*i +: 8];
         end
      end

      assign rd_word[8*i +: 8] = mem_q[idx_m];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rd_d    = rsp_rd_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         CLEAR: begin
            if (cnt_q == LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         RUN: begin
            // An accepted request on the same edge still completes; the clear starts next cycle.
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = CLEAR;
      endcase

      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      if (rd_acc) begin
         rsp_valid_d = 1'b1;
         rsp_rd_d    = in_range ? rd_word : '0;
         rsp_err_d   = !in_range;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rd_q    <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rd    = rsp_rd_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: doc/gc_mem_ctrl.md
Name: gc_mem_ctrl

Overview:
- Parametrised byte-lane data memory for the PPC datapath; next generation of the fixed 4-lane, 1K-word, async-read data RAM.
- Adds configurable lane count, depth and address width, a valid/ready request port, a registered read response with backpressure, and out-of-range error reporting.
- Adds a hardware clear sequencer that zeroes the array after reset and on request.
- Sits between the load/store unit and the on-chip data store.

Parameters:
LANES, 4, byte lanes per word; power of two, >= 1
ADDR_W, 12, byte-address width
DEPTH, 1024, number of words; DEPTH <= 2^(ADDR_W - log2(LANES))

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clr_req  in  1  pulse: start a soft clear of the whole array
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_be  in  LANES  byte enables; bit i enables lane i
req_addr  in  ADDR_W  byte address
req_wd  in  8*LANES  write data; lane i = req_wd[8i+7:8i]
rsp_valid  out  1  read response present
rsp_ready  in  1  consumer accepts response
rsp_rd  out  8*LANES  read data, lane i at [8i+7:8i]
rsp_err  out  1  response address was out of range
init_done  out  1  1 when no clear is in progress

Behaviour:
- Addressing:
  - Word index = req_addr[ADDR_W-1:log2(LANES)].
  - The low log2(LANES) bits are ignored; there is no misalignment trap.
  - Index >= DEPTH is out of range.
- FSM states: CLEAR, RUN.
- Reset (rst_n low, async):
  - state = CLEAR, clear counter = 0.
  - rsp_valid = 0, rsp_rd = 0, rsp_err = 0, init_done = 0, req_ready = 0.
  - Reset asserted mid-clear or mid-transaction aborts it; the in-flight response is lost and the clear restarts from word 0.
- CLEAR:
  - Each cycle writes all-zero to word[counter], then counter++.
  - After writing word DEPTH-1 the FSM goes to RUN on that edge, so CLEAR lasts exactly DEPTH cycles.
  - req_ready = 0 and init_done = 0 throughout.
- RUN:
  - init_done = 1.
  - req_ready = !rsp_valid || rsp_ready (combinational).
  - clr_req sampled high in RUN moves the FSM to CLEAR next cycle with counter = 0.
  - If clr_req and an accepted request coincide, the request completes first: a write updates the array, a read loads the response register. The clear begins the following cycle.
  - clr_req during CLEAR is ignored.
  - A pending response register is held through a clear until consumed. req_ready stays 0 during the clear.
- Write (accepted, req_we = 1):
  - For each i with req_be[i] = 1, lane i of the word is updated at this edge.
  - Lanes with req_be[i] = 0 are untouched.
  - No response is generated.
  - Out-of-range writes are dropped silently.
- Read (accepted, req_we = 0):
  - The response register loads on the accept edge: rsp_valid = 1 from the next cycle (latency 1).
  - rsp_rd = full word, regardless of req_be.
  - rsp_err = 0 in range.
  - Out of range: rsp_rd = 0, rsp_err = 1.
- Response:
  - rsp_valid, rsp_rd and rsp_err hold stable while rsp_valid && !rsp_ready.
  - rsp_valid clears on the rsp_ready edge unless a new read is accepted on the same edge; in that case the register reloads and rsp_valid stays 1.
  - Back-to-back reads sustain 1 per cycle while rsp_ready = 1.
- Ordering:
  - A write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
  - A read accepted in the same cycle as a write cannot occur (single port).
- Array is inferred RAM, one 8-bit array per lane, DEPTH entries each.

Test Plan:
- Reset then idle, LANES=4, DEPTH=1024 -> init_done rises after exactly 1024 cycles. Reading addr 0x000, 0x7FC and 0xFFC each returns 0x00000000 with rsp_err = 0.
- Write 0x11223344 BE=1111 to 0x010, then write 0xAABBCCDD BE=0101 to 0x010, then read 0x010 -> rsp_rd = 0x11BB33DD one cycle after accept.
- Reads to 0x020, 0x024, 0x028 back-to-back with rsp_ready held low 3 cycles after the first response -> req_ready = 0 while stalled. First response held stable; all three data values delivered in order with no loss.
- DEPTH=512, ADDR_W=12: read 0x800 -> rsp_rd = 0, rsp_err = 1. A write to 0x800 leaves word 0 unchanged.
- After writing 0xDEADBEEF to 0x040, pulse clr_req -> init_done = 0 for DEPTH cycles. req_ready = 0 during that window, and a later read of 0x040 returns 0x00000000.
- rst_n pulsed low mid-clear, and again with rsp_valid = 1 -> rsp_valid drops immediately (async). The clear restarts and takes a full DEPTH cycles to init_done.
